axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
AXI4-Lite responder (slave) that fronts one single-port synchronous SRAM macro used for imem/dmem. It accepts the read and write transactions issued by the CPU bus masters, arbitrates its independent read and write engines onto the single SRAM port, and returns R and B responses with OKAY or SLVERR. It allows one outstanding read and one outstanding write at a time, with no IDs and no bursts.

Parameters:
AXI_ADDR_BITS, 32, AXI address width
AXI_DATA_BITS, 32, AXI data width and SRAM word width
MEM_WORDS, 16384, SRAM depth in words (64 KiB)
BASE_ADDR, 32'h0000_0000, byte address of SRAM word 0

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
AWADDR  in  AXI_ADDR_BITS  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  AXI_DATA_BITS  write data
WSTRB  in  AXI_DATA_BITS/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  AXI_ADDR_BITS  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  AXI_DATA_BITS  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready
sram_cs  out  1  SRAM access enable
sram_we  out  AXI_DATA_BITS/8  per-byte write enable; all zeros means read
sram_addr  out  $clog2(MEM_WORDS)  word address
sram_wdata  out  AXI_DATA_BITS  SRAM write data
sram_rdata  in  AXI_DATA_BITS  SRAM read data, valid the cycle after a read access

Behaviour:
- Reset and clock: ARESETn is asynchronous and active-low; ACLK is the clock. During reset: BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, sram_cs=0, sram_we=0. Both FSMs reset to IDLE, and all capture flags clear.
- Decode: word index = (addr-BASE_ADDR)>>2. Address bits [1:0] are ignored. Any address outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS) is out of range: the response is SLVERR (2'b10) and the SRAM is not accessed. In-range responses are OKAY (2'b00).
- Read FSM:
  - R_IDLE: ARREADY=1. An AR handshake latches ARADDR, then goes to R_ACC if in range, else R_RESP with RDATA=0 and RRESP=SLVERR.
  - R_ACC: requests the SRAM port (sram_cs=1, sram_we=0). When granted, goes to R_CAP; when not granted, stays.
  - R_CAP: at the clock edge, RDATA<=sram_rdata, RRESP<=OKAY, RVALID<=1; goes to R_RESP.
  - R_RESP: RVALID stays high and RDATA/RRESP stay stable until RREADY. On the R handshake, RVALID<=0 and the FSM returns to R_IDLE.
  - ARREADY=0 in every state except R_IDLE.
  - Latency: with no conflict, RVALID is first high 3 cycles after the AR handshake edge.
- Write FSM:
  - W_IDLE: AWREADY = !aw_captured and WREADY = !w_captured. AW and W are accepted independently, in either order or in the same cycle; each is held in its own register. When both are captured, goes to W_MEM.
  - W_MEM: for an in-range address, requests the SRAM port with sram_we=WSTRB and sram_wdata=WDATA. On grant, the FSM sets BVALID<=1, BRESP<=OKAY and goes to W_RESP. For an out-of-range address there is no SRAM access; it goes straight to W_RESP with BRESP=SLVERR.
  - W_RESP: BVALID is held until BREADY. On the B handshake, BVALID<=0, both captured flags clear, and the FSM returns to W_IDLE.
  - AWREADY and WREADY are 0 outside W_IDLE.
  - WSTRB=0 performs an access with no byte enables and returns OKAY.
- Arbitration: fixed priority, write over read. A read in R_ACC waits exactly as long as W_MEM holds the port, which is one cycle per write. sram_cs is high in at most one engine per cycle.
- Concurrency: read and write engines run concurrently. A write followed by a read of the same address, where the write is granted first, returns the new data.
- Reset mid-operation: pending transactions are dropped, and no response is issued after reset deasserts.

Test Plan:
1. Reset, then AR=0x0000_0010 with RREADY=1 and SRAM word 4 preset to 0xDEADBEEF -> ARREADY=1 at reset exit; RVALID rises 3 cycles after the handshake; RDATA=0xDEADBEEF, RRESP=OKAY; ARREADY=1 again the cycle after the R handshake.
2. AW=0x20 two cycles before W=0x12345678 with WSTRB=4'b0011 and word 8 initially 0xFFFF_FFFF -> one sram_cs cycle with sram_we=4'b0011; BVALID with BRESP=OKAY; a following read returns 0xFFFF5678.
3. W presented before AW, then AW and W in the same cycle -> both cases complete with exactly one SRAM write each and one B response each.
4. AR and a completed AW+W targeting the SRAM in the same cycle -> the write gets sram_cs first, the read follows the next cycle, RVALID is delayed by exactly 1 cycle, and RDATA reflects the new data.
5. ARADDR=0x0001_0000 (out of range for the defaults) -> no sram_cs; RRESP=SLVERR, RDATA=0. An out-of-range AW/W gives BRESP=SLVERR with no SRAM write.
6. RREADY=0 for 5 cycles with RVALID high -> RDATA/RRESP stable and ARREADY=0 throughout. ARESETn pulsed low in R_RESP -> RVALID=0 immediately and ARREADY=1 after release.

Source files
------------

// File: rtl/axi_lite_sram_slave.sv
`timescale 1ns/1ps
// AXI4-Lite slave in front of one single-port synchronous SRAM macro.
// Independent read and write engines share the SRAM port; writes have priority.
module axi_lite_sram_slave #(
    parameter int                       AXI_ADDR_BITS = 32,
    parameter int                       AXI_DATA_BITS = 32,
    parameter int                       MEM_WORDS     = 16384,
    parameter logic [AXI_ADDR_BITS-1:0] BASE_ADDR     = 32'h0000_0000
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [AXI_ADDR_BITS-1:0]       AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [AXI_DATA_BITS-1:0]       WDATA,
    input  logic [AXI_DATA_BITS/8-1:0]     WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [AXI_ADDR_BITS-1:0]       ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [AXI_DATA_BITS-1:0]       RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic                           sram_cs,
    output logic [AXI_DATA_BITS/8-1:0]     sram_we,
    output logic [$clog2(MEM_WORDS)-1:0]   sram_addr,
    output logic [AXI_DATA_BITS-1:0]       sram_wdata,
    input  logic [AXI_DATA_BITS-1:0]       sram_rdata
);

    localparam int                       STRB_BITS   = AXI_DATA_BITS / 8;
    localparam int                       SRAM_AW     = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_BITS-1:0] ADDR_SPAN   = AXI_ADDR_BITS'(4 * MEM_WORDS);
    localparam logic [1:0]               RESP_OKAY   = 2'b00;
    localparam logic [1:0]               RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_ACC, R_CAP, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_MEM, W_RESP} w_state_t;

    r_state_t                 r_state;
    w_state_t                 w_state;
    logic [AXI_ADDR_BITS-1:0] ar_off;
    logic [AXI_ADDR_BITS-1:0] aw_off;
    logic                     ar_ok_in;
    logic                     aw_ok_in;
    logic [SRAM_AW-1:0]       ar_index;
    logic [SRAM_AW-1:0]       aw_index;
    logic                     aw_ok;
    logic                     aw_captured;
    logic                     w_captured;
    logic [AXI_DATA_BITS-1:0] w_data;
    logic [STRB_BITS-1:0]     w_strb;
    logic                     aw_hs;
    logic                     w_hs;
    logic                     write_req;
    logic                     read_grant;

    // Address decode happens at the handshake; only the word index and range flag are kept.
    assign ar_off   = ARADDR - BASE_ADDR;
    assign aw_off   = AWADDR - BASE_ADDR;
    assign ar_ok_in = (ARADDR >= BASE_ADDR) && (ar_off < ADDR_SPAN);
    assign aw_ok_in = (AWADDR >= BASE_ADDR) && (aw_off < ADDR_SPAN);

    assign ARREADY = (r_state == R_IDLE);
    assign AWREADY = (w_state == W_IDLE) && !aw_captured;
    assign WREADY  = (w_state == W_IDLE) && !w_captured;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    // Single SRAM port: a pending write always wins, the read waits in R_ACC.
    assign write_req  = (w_state == W_MEM) && aw_ok;
    assign read_grant = (r_state == R_ACC) && !write_req;
    assign sram_cs    = write_req || read_grant;
    assign sram_we    = write_req ? w_strb : '0;
    assign sram_addr  = write_req ? aw_index : ar_index;
    assign sram_wdata = w_data;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state  <= R_IDLE;
            ar_index <= '0;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID) begin
                        ar_index <= ar_off[SRAM_AW+1:2];
                        if (ar_ok_in) begin
                            r_state <= R_ACC;
                        end else begin
                            RDATA   <= '0;
                            RRESP   <= RESP_SLVERR;
                            RVALID  <= 1'b1;
                            r_state <= R_RESP;
                        end
                    end
                end
                R_ACC: begin
                    if (read_grant) r_state <= R_CAP;
                end
                R_CAP: begin
                    RDATA   <= sram_rdata;
                    RRESP   <= RESP_OKAY;
                    RVALID  <= 1'b1;
                    r_state <= R_RESP;
                end
                R_RESP: begin
                    if (RREADY) begin
                        RVALID  <= 1'b0;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // AW and W are captured independently; the engine moves on once both are held.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state     <= W_IDLE;
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            aw_index    <= '0;
            aw_ok       <= 1'b0;
            w_data      <= '0;
            w_strb      <= '0;
            BVALID      <= 1'b0;
            BRESP       <= RESP_OKAY;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_captured <= 1'b1;
                        aw_index    <= aw_off[SRAM_AW+1:2];
                        aw_ok       <= aw_ok_in;
                    end
                    if (w_hs) begin
                        w_captured <= 1'b1;
                        w_data     <= WDATA;
                        w_strb     <= WSTRB;
                    end
                    if ((aw_captured || aw_hs) && (w_captured || w_hs)) w_state <= W_MEM;
                end
                W_MEM: begin
                    BVALID  <= 1'b1;
                    BRESP   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                    w_state <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID      <= 1'b0;
                        aw_captured <= 1'b0;
                        w_captured  <= 1'b0;
                        w_state     <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
`timescale 1ns/1ps
// Randomized self-checking bench for axi_lite_sram_slave with a behavioural SRAM
// and an AXI-level memory reference model.
module tb_axi_lite_sram_slave;

    localparam int          MEM_WORDS = 16384;
    localparam logic [31:0] BASE      = 32'h0000_0000;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [31:0] ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        sram_cs;
    logic [3:0]  sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int          checks = 0;
    int          errors = 0;
    int          cs_count = 0;
    int          wr_count = 0;
    logic [3:0]  last_we;
    logic [31:0] sram_mem [int];
    logic [31:0] ref_mem [int];
    int          sm_idx;
    logic [31:0] sm_word;

    axi_lite_sram_slave #(
        .AXI_ADDR_BITS(32), .AXI_DATA_BITS(32), .MEM_WORDS(MEM_WORDS), .BASE_ADDR(BASE)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Preset SRAM contents; words 4 and 8 carry the fixed values the scenarios rely on.
    function automatic logic [31:0] init_word(int idx);
        logic [31:0] w;
        w = idx;
        if (idx == 4) return 32'hDEAD_BEEF;
        if (idx == 8) return 32'hFFFF_FFFF;
        return (w * 32'h0101_0101) ^ 32'hC3C3_0000;
    endfunction

    always @(posedge ACLK) begin
        if (sram_cs) begin
            cs_count++;
            last_we = sram_we;
            sm_idx  = int'(sram_addr);
            sm_word = sram_mem.exists(sm_idx) ? sram_mem[sm_idx] : init_word(sm_idx);
            if (sram_we == 4'b0000) begin
                sram_rdata <= sm_word;
            end else begin
                wr_count++;
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) sm_word[8*b +: 8] = sram_wdata[8*b +: 8];
                sram_mem[sm_idx] = sm_word;
            end
        end
    end

    function automatic bit ref_in_range(logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off >= 0) && (off < 4 * MEM_WORDS);
    endfunction

    function automatic int ref_index(logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) >> 2);
    endfunction

    function automatic logic [31:0] ref_read(logic [31:0] a);
        int idx;
        if (!ref_in_range(a)) return 32'h0;
        idx = ref_index(a);
        return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
    endfunction

    function automatic logic [1:0] ref_resp(logic [31:0] a);
        return ref_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (ref_in_range(a)) begin
            w = ref_read(a);
            for (int b = 0; b < 4; b++)
                if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            ref_mem[ref_index(a)] = w;
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int n;
        ARADDR = addr; ARVALID = 1'b1; RREADY = 1'b1; n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        tick();
        ARVALID = 1'b0; lat = 1;
        while (!RVALID && lat < 50) begin tick(); lat++; end
        checks++;
        if (!RVALID) begin errors++; $display("[TB] FAIL read_timeout: RVALID %b expected 1 for addr %h", RVALID, addr); end
        data = RDATA; resp = RRESP;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_delay, input int w_delay, output logic [1:0] resp);
        bit aw_done, w_done, aw_fire, w_fire;
        int c, n;
        aw_done = 0; w_done = 0; BREADY = 1'b1; c = 0;
        while (!(aw_done && w_done) && c < 50) begin
            AWADDR = addr; WDATA = data; WSTRB = strb;
            AWVALID = !aw_done && (c >= aw_delay);
            WVALID  = !w_done && (c >= w_delay);
            aw_fire = AWVALID && AWREADY;
            w_fire  = WVALID && WREADY;
            tick(); c++;
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
        end
        AWVALID = 1'b0; WVALID = 1'b0; n = 0;
        while (!BVALID && n < 50) begin tick(); n++; end
        checks++;
        if (!BVALID) begin errors++; $display("[TB] FAIL write_timeout: BVALID %b expected 1 for addr %h", BVALID, addr); end
        resp = BRESP;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) tick();
        checks++; if (BVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_bvalid: got %b expected 0", BVALID); end
        checks++; if (RVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", RVALID); end
        checks++; if ({BRESP, RRESP} !== 4'b0) begin errors++; $display("[TB] FAIL reset_resp: got %b/%b expected 00/00", BRESP, RRESP); end
        checks++; if (RDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", RDATA); end
        checks++; if ({sram_cs, sram_we} !== 5'b0) begin errors++; $display("[TB] FAIL reset_sram: cs %b we %b expected 0/0", sram_cs, sram_we); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        checks++; if ({ARREADY, AWREADY, WREADY} !== 3'b111) begin errors++; $display("[TB] FAIL reset_ready: ar/aw/w %b%b%b expected 111", ARREADY, AWREADY, WREADY); end
    endtask

    task automatic test_read_basic();
        logic [31:0] d; logic [1:0] r; int lat, c0;
        c0 = cs_count;
        do_read(32'h0000_0010, d, r, lat);
        checks++; if (d !== ref_read(32'h10)) begin errors++; $display("[TB] FAIL read_data: got %h expected %h", d, ref_read(32'h10)); end
        checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL read_resp: got %b expected 00", r); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
        checks++; if (cs_count - c0 !== 1) begin errors++; $display("[TB] FAIL read_cs_cycles: got %0d expected 1", cs_count - c0); end
        checks++; if (ARREADY !== 1'b1) begin errors++; $display("[TB] FAIL read_arready_after: got %b expected 1", ARREADY); end
    endtask

    task automatic test_write_strobe();
        logic [31:0] d; logic [1:0] r; int lat, c0, w0;
        c0 = cs_count; w0 = wr_count;
        do_write(32'h0000_0020, 32'h1234_5678, 4'b0011, 0, 2, r);
        ref_write(32'h20, 32'h1234_5678, 4'b0011);
        checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL strobe_bresp: got %b expected 00", r); end
        checks++; if (wr_count - w0 !== 1 || cs_count - c0 !== 1) begin errors++; $display("[TB] FAIL strobe_access: writes %0d cs %0d expected 1 1", wr_count - w0, cs_count - c0); end
        checks++; if (last_we !== 4'b0011) begin errors++; $display("[TB] FAIL strobe_we: got %b expected 0011", last_we); end
        checks++; if (BVALID !== 1'b0) begin errors++; $display("[TB] FAIL strobe_bvalid_drop: got %b expected 0", BVALID); end
        do_read(32'h0000_0020, d, r, lat);
        checks++; if (d !== ref_read(32'h20)) begin errors++; $display("[TB] FAIL strobe_readback: got %h expected %h", d, ref_read(32'h20)); end
    endtask

    task automatic test_write_orders();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] r; int lat, c0, w0;
        for (int k = 0; k < 2; k++) begin
            a = $urandom_range(16, MEM_WORDS - 1) * 4;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            c0 = cs_count; w0 = wr_count;
            do_write(a, d, s, (k == 0) ? 3 : 0, 0, r);
            ref_write(a, d, s);
            checks++; if (r !== 2'b00) begin errors++; $display("[TB] FAIL order%0d_bresp: got %b expected 00", k, r); end
            checks++; if (wr_count - w0 !== 1 || cs_count - c0 !== 1) begin errors++; $display("[TB] FAIL order%0d_access: writes %0d cs %0d expected 1 1", k, wr_count - w0, cs_count - c0); end
            checks++; if (BVALID !== 1'b0) begin errors++; $display("[TB] FAIL order%0d_single_b: BVALID %b expected 0", k, BVALID); end
            do_read(a, rd, r, lat);
            checks++; if (rd !== ref_read(a)) begin errors++; $display("[TB] FAIL order%0d_readback: got %h expected %h", k, rd, ref_read(a)); end
        end
    endtask

    task automatic test_conflict();
        logic [31:0] a, d; logic [3:0] s; int lat, c0;
        a = $urandom_range(16, MEM_WORDS - 1) * 4;
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        c0 = cs_count;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        ref_write(a, d, s);
        checks++; if ({sram_cs, sram_we} !== {1'b1, s} || sram_addr !== 14'(ref_index(a))) begin errors++; $display("[TB] FAIL conflict_write_first: cs %b we %b addr %h expected 1 %b %h", sram_cs, sram_we, sram_addr, s, 14'(ref_index(a))); end
        tick();
        checks++; if ({BVALID, BRESP} !== 3'b100) begin errors++; $display("[TB] FAIL conflict_bresp: valid %b resp %b expected 1 00", BVALID, BRESP); end
        checks++; if ({sram_cs, sram_we} !== 5'b10000) begin errors++; $display("[TB] FAIL conflict_read_next: cs %b we %b expected 1 0000", sram_cs, sram_we); end
        lat = 2;
        while (!RVALID && lat < 50) begin tick(); lat++; end
        checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL conflict_latency: got %0d expected 4", lat); end
        checks++; if (RDATA !== ref_read(a) || RRESP !== 2'b00) begin errors++; $display("[TB] FAIL conflict_rdata: got %h/%b expected %h/00", RDATA, RRESP, ref_read(a)); end
        tick();
        RREADY = 1'b0; BREADY = 1'b0;
        checks++; if (cs_count - c0 !== 2) begin errors++; $display("[TB] FAIL conflict_cs_cycles: got %0d expected 2", cs_count - c0); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] a, d, rd; logic [1:0] r; int lat, c0, w0;
        c0 = cs_count;
        do_read(32'h0001_0000, rd, r, lat);
        checks++; if (r !== 2'b10 || rd !== 32'h0) begin errors++; $display("[TB] FAIL oor_read: got %h/%b expected 00000000/10", rd, r); end
        a = $urandom_range(32'hFFFF_FFFF, 32'h0001_0000);
        do_read(a, rd, r, lat);
        checks++; if (r !== ref_resp(a) || rd !== 32'h0) begin errors++; $display("[TB] FAIL oor_read_rand: got %h/%b expected 00000000/%b", rd, r, ref_resp(a)); end
        checks++; if (cs_count - c0 !== 0) begin errors++; $display("[TB] FAIL oor_read_cs: got %0d expected 0", cs_count - c0); end
        d = $urandom;
        do_write(32'h0000_FFFC, d, 4'hF, 1, 0, r);
        ref_write(32'h0000_FFFC, d, 4'hF);
        do_read(32'h0000_FFFF, rd, r, lat);
        checks++; if (rd !== ref_read(32'h0000_FFFC) || r !== 2'b00) begin errors++; $display("[TB] FAIL last_word: got %h/%b expected %h/00", rd, r, ref_read(32'h0000_FFFC)); end
        c0 = cs_count; w0 = wr_count;
        do_write(32'h0001_0004, $urandom, 4'hF, 0, 0, r);
        checks++; if (r !== 2'b10) begin errors++; $display("[TB] FAIL oor_bresp: got %b expected 10", r); end
        checks++; if (cs_count - c0 !== 0 || wr_count - w0 !== 0) begin errors++; $display("[TB] FAIL oor_write_access: cs %0d writes %0d expected 0 0", cs_count - c0, wr_count - w0); end
        c0 = cs_count; w0 = wr_count;
        do_write(32'h0000_0030, $urandom, 4'h0, 0, 0, r);
        checks++; if (r !== 2'b00 || cs_count - c0 !== 1 || wr_count - w0 !== 0) begin errors++; $display("[TB] FAIL zero_strobe: resp %b cs %0d writes %0d expected 00 1 0", r, cs_count - c0, wr_count - w0); end
        do_read(32'h0000_0030, rd, r, lat);
        checks++; if (rd !== ref_read(32'h30)) begin errors++; $display("[TB] FAIL zero_strobe_readback: got %h expected %h", rd, ref_read(32'h30)); end
    endtask

    task automatic test_rready_stall();
        logic [31:0] a, exp; int n; bit seen;
        a = $urandom_range(0, MEM_WORDS - 1) * 4;
        exp = ref_read(a);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b0;
        tick();
        ARVALID = 1'b0; n = 0;
        while (!RVALID && n < 50) begin tick(); n++; end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({RVALID, ARREADY, RRESP, RDATA} !== {1'b1, 1'b0, 2'b00, exp}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: valid %b arready %b resp %b data %h expected 1 0 00 %h", k, RVALID, ARREADY, RRESP, RDATA, exp);
            end
            tick();
        end
        ARESETn = 1'b0;
        #1;
        checks++; if (RVALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_rvalid: got %b expected 0", RVALID); end
        @(negedge ACLK);
        ARESETn = 1'b1;
        tick();
        checks++; if (ARREADY !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid_arready: got %b expected 1", ARREADY); end
        RREADY = 1'b1; seen = 0;
        repeat (5) begin if (RVALID) seen = 1; tick(); end
        RREADY = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_stale_resp: RVALID seen %b expected 0", seen); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] r; int lat;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom_range(32'hFFFF_FFFF, 32'h0001_0000);
            else a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), r);
                ref_write(a, d, s);
                checks++; if (r !== ref_resp(a)) begin errors++; $display("[TB] FAIL rand_bresp%0d: addr %h got %b expected %b", k, a, r, ref_resp(a)); end
            end else begin
                do_read(a, rd, r, lat);
                checks++; if (rd !== ref_read(a) || r !== ref_resp(a)) begin errors++; $display("[TB] FAIL rand_read%0d: addr %h got %h/%b expected %h/%b", k, a, rd, r, ref_read(a), ref_resp(a)); end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        ARESETn = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        test_reset();
        test_read_basic();
        test_write_strobe();
        test_write_orders();
        test_conflict();
        test_out_of_range();
        test_rready_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
